// File: rtl/hmmm_pkg.sv
// Shared definitions for the hmmm program loader: state encodings, default widths
// and the one-hot command codes formed from {pgrm_addr, pgrm_data, pgrm_read}.
package hmmm_pkg;

    localparam int unsigned DEF_DATA_W = 16;
    localparam int unsigned DEF_ADDR_W = 8;

    typedef enum logic [1:0] {
        ST_LOAD    = 2'd0,
        ST_RD_WAIT = 2'd1,
        ST_RD_OUT  = 2'd2,
        ST_RUN     = 2'd3
    } loader_state_e;

    localparam logic [2:0] CMD_NONE = 3'b000;
    localparam logic [2:0] CMD_ADDR = 3'b100;
    localparam logic [2:0] CMD_DATA = 3'b010;
    localparam logic [2:0] CMD_READ = 3'b001;

endpackage

// File: rtl/hmmm_prog_loader_if.sv
// Shared-bus and instruction-memory signals of the program loader.
// The slave modport is the loader itself; master is the host/memory side.
interface hmmm_prog_loader_if #(
    parameter int unsigned DATA_W = 16,
    parameter int unsigned ADDR_W = 8
);
    logic              pgrm_addr;
    logic              pgrm_data;
    logic              pgrm_read;
    logic              burst_en;
    logic              run;
    logic [DATA_W-1:0] bus_in;
    logic [DATA_W-1:0] bus_out;
    logic              bus_oe;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;
    logic              core_hold;
    logic              busy;
    logic              err;
    logic [DATA_W-1:0] checksum;
    logic [ADDR_W:0]   word_count;

    modport slave (
        input  pgrm_addr, pgrm_data, pgrm_read, burst_en, run, bus_in, mem_rdata,
        output bus_out, bus_oe, mem_we, mem_addr, mem_wdata,
        output core_hold, busy, err, checksum, word_count
    );

    modport master (
        output pgrm_addr, pgrm_data, pgrm_read, burst_en, run, bus_in, mem_rdata,
        input  bus_out, bus_oe, mem_we, mem_addr, mem_wdata,
        input  core_hold, busy, err, checksum, word_count
    );
endinterface

// File: rtl/hmmm_prog_loader.sv
// Loads instruction words from the shared bus into the hmmm core's instruction memory,
// supports read-back, keeps checksum/word count/sticky error, and gates core reset.
module hmmm_prog_loader
    import hmmm_pkg::*;
#(
    parameter int unsigned DATA_W = DEF_DATA_W,
    parameter int unsigned ADDR_W = DEF_ADDR_W,
    parameter int unsigned DEPTH  = 256
) (
    input  logic                 clk,
    input  logic                 rst_n,
    hmmm_prog_loader_if.slave    bus
);

    localparam logic [DATA_W:0]   DEPTH_CMP = (DATA_W+1)'(DEPTH);
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

    loader_state_e     state_q;
    logic [ADDR_W-1:0] addr_q;
    logic              addr_valid_q;
    logic [DATA_W-1:0] bus_out_q;
    logic              bus_oe_q;
    logic              mem_we_q;
    logic [ADDR_W-1:0] mem_addr_q;
    logic [DATA_W-1:0] mem_wdata_q;
    logic              core_hold_q;
    logic              busy_q;
    logic              err_q;
    logic [DATA_W-1:0] checksum_q;
    logic [ADDR_W:0]   word_count_q;

    logic [2:0]        cmd;
    logic              any_strobe;
    logic              new_session;
    logic              addr_valid_d;
    logic              err_d;
    logic [DATA_W-1:0] checksum_d;
    logic [ADDR_W:0]   word_count_d;
    logic [ADDR_W:0]   word_count_inc;
    logic              addr_in_range;

    // A strobe in RUN opens a new session first; the strobe is then decoded against
    // the cleared session state, so the FSM below sees one uniform set of bases.
    always_comb begin
        cmd            = {bus.pgrm_addr, bus.pgrm_data, bus.pgrm_read};
        any_strobe     = |cmd;
        new_session    = (state_q == ST_RUN) && any_strobe;
        addr_valid_d   = new_session ? 1'b0 : addr_valid_q;
        err_d          = new_session ? 1'b0 : err_q;
        checksum_d     = new_session ? '0 : checksum_q;
        word_count_d   = new_session ? '0 : word_count_q;
        word_count_inc = (word_count_d == '1) ? word_count_d : word_count_d + 1'b1;
        addr_in_range  = {1'b0, bus.bus_in} < DEPTH_CMP;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_LOAD;
            addr_q       <= '0;
            addr_valid_q <= 1'b0;
            bus_out_q    <= '0;
            bus_oe_q     <= 1'b0;
            mem_we_q     <= 1'b0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
            core_hold_q  <= 1'b1;
            busy_q       <= 1'b0;
            err_q        <= 1'b0;
            checksum_q   <= '0;
            word_count_q <= '0;
        end else begin
            mem_we_q <= 1'b0;
            bus_oe_q <= 1'b0;
            case (state_q)
                ST_LOAD, ST_RUN: begin
                    if (state_q == ST_LOAD && bus.run) begin
                        core_hold_q <= 1'b0;
                        state_q     <= ST_RUN;
                    end else if (state_q == ST_LOAD || any_strobe) begin
                        state_q      <= ST_LOAD;
                        core_hold_q  <= 1'b1;
                        addr_valid_q <= addr_valid_d;
                        err_q        <= err_d;
                        checksum_q   <= checksum_d;
                        word_count_q <= word_count_d;
                        case (cmd)
                            CMD_NONE: ;
                            CMD_ADDR: begin
                                if (addr_in_range) begin
                                    addr_q       <= bus.bus_in[ADDR_W-1:0];
                                    addr_valid_q <= 1'b1;
                                end else begin
                                    addr_valid_q <= 1'b0;
                                    err_q        <= 1'b1;
                                end
                            end
                            CMD_DATA: begin
                                if (addr_valid_d) begin
                                    mem_we_q     <= 1'b1;
                                    mem_addr_q   <= addr_q;
                                    mem_wdata_q  <= bus.bus_in;
                                    checksum_q   <= checksum_d + bus.bus_in;
                                    word_count_q <= word_count_inc;
                                    if (bus.burst_en) begin
                                        if (addr_q == LAST_ADDR) begin
                                            addr_valid_q <= 1'b0;
                                            err_q        <= 1'b1;
                                        end else begin
                                            addr_q <= addr_q + 1'b1;
                                        end
                                    end
                                end else begin
                                    err_q <= 1'b1;
                                end
                            end
                            CMD_READ: begin
                                if (addr_valid_d) begin
                                    mem_addr_q <= addr_q;
                                    busy_q     <= 1'b1;
                                    state_q    <= ST_RD_WAIT;
                                end else begin
                                    err_q <= 1'b1;
                                end
                            end
                            default: err_q <= 1'b1;
                        endcase
                    end
                end
                ST_RD_WAIT: begin
                    bus_out_q <= bus.mem_rdata;
                    state_q   <= ST_RD_OUT;
                    if (any_strobe) err_q <= 1'b1;
                end
                ST_RD_OUT: begin
                    bus_oe_q <= 1'b1;
                    busy_q   <= 1'b0;
                    state_q  <= ST_LOAD;
                    if (any_strobe) err_q <= 1'b1;
                end
                default: state_q <= ST_LOAD;
            endcase
        end
    end

    assign bus.bus_out    = bus_out_q;
    assign bus.bus_oe     = bus_oe_q;
    assign bus.mem_we     = mem_we_q;
    assign bus.mem_addr   = mem_addr_q;
    assign bus.mem_wdata  = mem_wdata_q;
    assign bus.core_hold  = core_hold_q;
    assign bus.busy       = busy_q;
    assign bus.err        = err_q;
    assign bus.checksum   = checksum_q;
    assign bus.word_count = word_count_q;

endmodule

// File: tb/tb_hmmm_prog_loader.sv
// Directed self-checking bench for hmmm_prog_loader with a small instruction memory model
// and a write log collected from the memory port.
module tb_hmmm_prog_loader;

    localparam int unsigned DW = 16;
    localparam int unsigned AW = 8;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    hmmm_prog_loader_if #(.DATA_W(DW), .ADDR_W(AW)) bus_if ();

    hmmm_prog_loader #(.DATA_W(DW), .ADDR_W(AW), .DEPTH(256)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_if)
    );

    logic [DW-1:0] mem [256];
    assign bus_if.mem_rdata = mem[bus_if.mem_addr];
    always @(posedge clk) if (bus_if.mem_we) mem[bus_if.mem_addr] <= bus_if.mem_wdata;

    // Every cycle mem_we is high is logged, so a stretched pulse shows as an extra entry.
    logic [AW-1:0] wr_addr [$];
    logic [DW-1:0] wr_data [$];
    always @(negedge clk) begin
        if (bus_if.mem_we === 1'b1) begin
            wr_addr.push_back(bus_if.mem_addr);
            wr_data.push_back(bus_if.mem_wdata);
        end
    end

    int unsigned n_cmp = 0;
    int unsigned n_err = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic strobe(input logic a, input logic d, input logic r, input logic rn,
                          input logic [DW-1:0] val);
        @(negedge clk);
        bus_if.pgrm_addr = a;
        bus_if.pgrm_data = d;
        bus_if.pgrm_read = r;
        bus_if.run       = rn;
        bus_if.bus_in    = val;
        @(negedge clk);
        bus_if.pgrm_addr = 1'b0;
        bus_if.pgrm_data = 1'b0;
        bus_if.pgrm_read = 1'b0;
        bus_if.run       = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        wr_addr.delete();
        wr_data.delete();
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = '0;
        bus_if.pgrm_addr = 1'b0;
        bus_if.pgrm_data = 1'b0;
        bus_if.pgrm_read = 1'b0;
        bus_if.burst_en  = 1'b0;
        bus_if.run       = 1'b0;
        bus_if.bus_in    = '0;

        // Reset values
        repeat (2) @(negedge clk);
        check_eq("rst_core_hold", bus_if.core_hold, 1);
        check_eq("rst_bus_oe", bus_if.bus_oe, 0);
        check_eq("rst_mem_we", bus_if.mem_we, 0);
        check_eq("rst_mem_addr", bus_if.mem_addr, 0);
        check_eq("rst_busy", bus_if.busy, 0);
        check_eq("rst_err", bus_if.err, 0);
        check_eq("rst_checksum", bus_if.checksum, 0);
        check_eq("rst_word_count", bus_if.word_count, 0);
        rst_n = 1'b1;

        // Two single-word writes
        strobe(1, 0, 0, 0, 16'd0);
        strobe(0, 1, 0, 0, 16'h1105);
        strobe(1, 0, 0, 0, 16'd1);
        strobe(0, 1, 0, 0, 16'h122A);
        @(negedge clk);
        check_eq("t1_nwrites", wr_addr.size(), 2);
        if (wr_addr.size() == 2) begin
            check_eq("t1_w0_addr", wr_addr[0], 0);
            check_eq("t1_w0_data", wr_data[0], 16'h1105);
            check_eq("t1_w1_addr", wr_addr[1], 1);
            check_eq("t1_w1_data", wr_data[1], 16'h122A);
        end
        check_eq("t1_checksum", bus_if.checksum, 16'h232F);
        check_eq("t1_word_count", bus_if.word_count, 2);
        check_eq("t1_err", bus_if.err, 0);

        // Burst of three words from address 2
        do_reset();
        bus_if.burst_en = 1'b1;
        strobe(1, 0, 0, 0, 16'd2);
        strobe(0, 1, 0, 0, 16'hBE08);
        strobe(0, 1, 0, 0, 16'h0D02);
        strobe(0, 1, 0, 0, 16'h6120);
        @(negedge clk);
        check_eq("t2_nwrites", wr_addr.size(), 3);
        if (wr_addr.size() == 3) begin
            check_eq("t2_w0_addr", wr_addr[0], 2);
            check_eq("t2_w1_addr", wr_addr[1], 3);
            check_eq("t2_w2_addr", wr_addr[2], 4);
            check_eq("t2_w2_data", wr_data[2], 16'h6120);
        end
        check_eq("t2_word_count", bus_if.word_count, 3);
        check_eq("t2_checksum", bus_if.checksum, 16'h2C2A);
        bus_if.burst_en = 1'b0;
        strobe(0, 1, 0, 0, 16'h0001);
        @(negedge clk);
        check_eq("t2_next_addr", wr_addr.size() == 4 ? wr_addr[3] : 8'hEE, 5);
        check_eq("t2_err", bus_if.err, 0);

        // Burst running off the end of memory
        wr_addr.delete();
        wr_data.delete();
        bus_if.burst_en = 1'b1;
        strobe(1, 0, 0, 0, 16'd255);
        strobe(0, 1, 0, 0, 16'hAAAA);
        strobe(0, 1, 0, 0, 16'h5555);
        @(negedge clk);
        check_eq("t3_nwrites", wr_addr.size(), 1);
        if (wr_addr.size() == 1) begin
            check_eq("t3_w0_addr", wr_addr[0], 255);
            check_eq("t3_w0_data", wr_data[0], 16'hAAAA);
        end
        check_eq("t3_err", bus_if.err, 1);
        strobe(0, 0, 1, 0, 16'd0);
        check_eq("t3_read_ignored", bus_if.busy, 0);
        bus_if.burst_en = 1'b0;

        // Read-back latency
        do_reset();
        strobe(1, 0, 0, 0, 16'd8);
        strobe(0, 1, 0, 0, 16'h6D11);
        @(negedge clk);
        bus_if.pgrm_read = 1'b1;
        @(negedge clk);
        bus_if.pgrm_read = 1'b0;
        check_eq("t4_busy_wait", bus_if.busy, 1);
        check_eq("t4_oe_wait", bus_if.bus_oe, 0);
        @(negedge clk);
        check_eq("t4_busy_out", bus_if.busy, 1);
        check_eq("t4_oe_out", bus_if.bus_oe, 0);
        @(negedge clk);
        check_eq("t4_oe_high", bus_if.bus_oe, 1);
        check_eq("t4_bus_out", bus_if.bus_out, 16'h6D11);
        check_eq("t4_busy_done", bus_if.busy, 0);
        @(negedge clk);
        check_eq("t4_oe_low", bus_if.bus_oe, 0);
        check_eq("t4_err", bus_if.err, 0);

        // Conflicting strobes, run, and new session
        wr_addr.delete();
        wr_data.delete();
        strobe(1, 1, 0, 0, 16'd1);
        @(negedge clk);
        check_eq("t5_conflict_nowrite", wr_addr.size(), 0);
        check_eq("t5_conflict_err", bus_if.err, 1);
        strobe(0, 0, 0, 1, 16'd0);
        check_eq("t5_run_hold", bus_if.core_hold, 0);
        strobe(1, 0, 0, 0, 16'd0);
        check_eq("t5_new_hold", bus_if.core_hold, 1);
        check_eq("t5_new_err", bus_if.err, 0);
        check_eq("t5_new_checksum", bus_if.checksum, 0);
        check_eq("t5_new_wc", bus_if.word_count, 0);
        strobe(0, 1, 0, 0, 16'h0042);
        @(negedge clk);
        check_eq("t5_new_addr", wr_addr.size() == 1 ? wr_addr[0] : 8'hEE, 0);
        check_eq("t5_new_sum", bus_if.checksum, 16'h0042);

        // Reset while the read is in flight
        strobe(1, 0, 0, 0, 16'd8);
        @(negedge clk);
        bus_if.pgrm_read = 1'b1;
        @(negedge clk);
        bus_if.pgrm_read = 1'b0;
        rst_n = 1'b0;
        #1;
        check_eq("t6_busy", bus_if.busy, 0);
        check_eq("t6_hold", bus_if.core_hold, 1);
        check_eq("t6_checksum", bus_if.checksum, 0);
        check_eq("t6_wc", bus_if.word_count, 0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check_eq("t6_oe", bus_if.bus_oe, 0);
        end
        rst_n = 1'b1;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
